// File: rtl/mux_rr_arbiter.sv
// Round-robin owner selection for a shared N:1 data mux with a valid/ready output port.
// Optional macro ARB_TIMEOUT_EN forces a release after MAX_HOLD transfers per grant.
module mux_rr_arbiter #(
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         last,
  input  logic [N*DW-1:0]      din,
  input  logic                 dout_ready,
  output logic [DW-1:0]        dout,
  output logic                 dout_valid,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] sel,
  output logic                 busy
);

  localparam int SW = $clog2(N);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [SW-1:0]   r_sel;
  logic [SW-1:0]   w_sel_next;
  logic [SW-1:0]   r_ptr;
  logic [SW-1:0]   w_ptr_next;
  logic [SW-1:0]   w_sel_inc;
  logic [SW-1:0]   w_hi_idx;
  logic [SW-1:0]   w_lo_idx;
  logic [SW-1:0]   w_pick;
  logic            w_hi_found;
  logic            w_own_req;
  logic            w_own_last;
  logic            w_busy;
  logic            w_xfer;
  logic            w_hold_done;
  logic [DW-1:0]   w_word;

  generate
    if (N < 2 || N > 16 || MAX_HOLD < 1) begin : g_bad_param
      $error("mux_rr_arbiter: N must be 2..16 and MAX_HOLD >= 1");
    end
  endgenerate

  // Lowest requester at or above ptr wins; otherwise lowest overall, which is then below ptr.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_idx = SW'(i);
        if (SW'(i) >= r_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SW'(i);
        end
      end
    end
    w_pick = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < N; i++) begin
      if (r_sel == SW'(i)) begin
        w_word = din[i*DW +: DW];
      end
    end
  end

  assign w_own_req  = req[r_sel];
  assign w_own_last = last[r_sel];
  assign w_busy     = (r_state == S_GRANT);
  assign w_xfer     = w_busy & w_own_req & dout_ready;
  assign w_sel_inc  = (r_sel == SW'(N - 1)) ? '0 : r_sel + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] r_hold;

  // Counter rests at zero while idle, so every new grant starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (!w_busy) begin
      r_hold <= '0;
    end else if (w_xfer) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  assign w_hold_done = (r_hold == HW'(MAX_HOLD - 1));
`else
  assign w_hold_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_ptr   <= w_ptr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_ptr_next   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_next = S_GRANT;
          w_sel_next   = w_pick;
        end
      end
      S_GRANT: begin
        // Withdrawal releases without a transfer; otherwise release rides on a transfer.
        if (!w_own_req || (w_xfer && (w_own_last || w_hold_done))) begin
          w_state_next = S_IDLE;
          w_ptr_next   = w_sel_inc;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = w_busy & (r_sel == SW'(gi));
    end
  endgenerate

  assign sel        = r_sel;
  assign busy       = w_busy;
  assign dout_valid = w_busy & w_own_req;
  assign dout       = dout_valid ? w_word : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, rotation, stalls, withdrawal and hold limit.
module tb_mux_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*DW-1:0] din;
  logic            dout_ready;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic [N-1:0]    grant;
  logic [1:0]      sel;
  logic            busy;

  int checks;
  int errors;

  mux_rr_arbiter #(.N(N), .DW(DW), .MAX_HOLD(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .last       (last),
    .din        (din),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .grant      (grant),
    .sel        (sel),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("ok   %-14s observed=%0h expected=%0h", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [DW-1:0] val);
    din[idx*DW +: DW] = val;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    req        = '0;
    last       = '0;
    dout_ready = 1'b0;
    din        = '0;
    for (int i = 0; i < N; i++) set_word(i, 8'hA0 + 8'(i));
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    cyc();
    rst_n = 1'b1;

    // 1: asynchronous reset in the middle of a grant
    req = 4'b0100;
    cyc();
    chk("t1_grant", 32'(grant), 32'h4);
    chk("t1_sel", 32'(sel), 32'h2);
    chk("t1_dout", 32'(dout), 32'hA2);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_grant", 32'(grant), 32'h0);
    chk("t1_rst_busy", 32'(busy), 32'h0);
    chk("t1_rst_valid", 32'(dout_valid), 32'h0);
    rst_n = 1'b1;
    req   = 4'b0001;
    cyc();
    chk("t1_regrant", 32'(grant), 32'h1);
    req = 4'b0000;
    cyc();
    chk("t1_idle", 32'(busy), 32'h0);

    // 2: full rotation with single-word bursts
    do_reset();
    req        = 4'b1111;
    last       = 4'b1111;
    dout_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      cyc();
      chk("t2_grant", 32'(grant), 32'(4'b0001 << (g % 4)));
      chk("t2_dout", 32'(dout), 32'(8'hA0 + 8'(g % 4)));
      cyc();
      chk("t2_bubble", 32'(grant), 32'h0);
    end
    req  = 4'b0000;
    last = 4'b0000;

    // 3: three-word burst from owner 2 with a two-cycle stall (ptr is 1 here)
    req = 4'b0100;
    set_word(2, 8'h11);
    cyc();
    chk("t3_grant", 32'(grant), 32'h4);
    chk("t3_w1", 32'(dout), 32'h11);
    cyc();
    set_word(2, 8'h22);
    dout_ready = 1'b0;
    #1;
    chk("t3_w2", 32'(dout), 32'h22);
    cyc();
    chk("t3_stall_dout", 32'(dout), 32'h22);
    chk("t3_stall_valid", 32'(dout_valid), 32'h1);
    chk("t3_stall_grant", 32'(grant), 32'h4);
    cyc();
    chk("t3_stall2_dout", 32'(dout), 32'h22);
    dout_ready = 1'b1;
    cyc();
    set_word(2, 8'h33);
    last = 4'b0100;
    #1;
    chk("t3_w3", 32'(dout), 32'h33);
    chk("t3_w3_grant", 32'(grant), 32'h4);
    cyc();
    chk("t3_release", 32'(busy), 32'h0);
    last = 4'b0000;
    req  = 4'b1111;
    cyc();
    chk("t3_ptr3", 32'(grant), 32'h8);
    req = 4'b0000;
    cyc();
    chk("t3_withdraw", 32'(grant), 32'h0);

    // 4: owner 1 withdraws before last, then wrap from ptr=2
    req = 4'b0010;
    cyc();
    chk("t4_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    #1;
    chk("t4_no_valid", 32'(dout_valid), 32'h0);
    chk("t4_no_dout", 32'(dout), 32'h0);
    cyc();
    chk("t4_release", 32'(grant), 32'h0);
    req = 4'b0001;
    cyc();
    chk("t4_wrap", 32'(grant), 32'h1);
    chk("t4_wrap_sel", 32'(sel), 32'h0);
    req = 4'b0000;
    cyc();

    // 5/6: owner 0 never asserts last while owner 1 waits
    do_reset();
    req        = 4'b0011;
    last       = 4'b0000;
    dout_ready = 1'b1;
    cyc();
`ifdef ARB_TIMEOUT_EN
    for (int t = 0; t < 8; t++) begin
      chk("t5_hold", 32'(grant), 32'h1);
      cyc();
    end
    chk("t5_bubble", 32'(grant), 32'h0);
    cyc();
    chk("t5_next", 32'(grant), 32'h2);
`else
    for (int t = 0; t < 22; t++) begin
      chk("t6_hold", 32'(grant), 32'h1);
      cyc();
    end
`endif
    req = 4'b0000;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
